// File: rtl/slicer_mer.sv
// 4-ASK slicer with windowed mean-squared-error measurement.
// Stage 1 slices the decision variable, and stage 2 averages the squared error over 2^LOG2_N symbols.
module slicer_mer #(
  parameter int LOG2_N = 4,
  parameter int DW     = 18
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sym_clk_en,
  input  logic                 clr_win,
  input  logic signed [DW-1:0] dec_var,
  input  logic signed [DW-1:0] ref_lvl,
  input  logic signed [DW-1:0] map_out_pwr,
  output logic [1:0]           sym_out,
  output logic signed [DW-1:0] err_out,
  output logic                 sym_valid,
  output logic [DW-1:0]        err_pwr,
  output logic signed [DW-1:0] sig_pwr,
  output logic                 pwr_valid
);

  localparam int AW = DW + LOG2_N;

  // One extra bit keeps 1.5r and x - level exact before truncation back to DW.
  logic signed [DW:0]     r_ext, x_ext, half_lvl, full_lvl, level, err_full;
  logic [1:0]             sym_d;
  logic signed [2*DW-1:0] err_ext, prod;
  logic [DW-1:0]          sq;
  logic [AW-1:0]          acc, acc_sum;
  logic [LOG2_N-1:0]      cnt;
  logic                   unused_bits;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    r_ext    = ref_lvl[DW-1] ? '0 : {1'b0, ref_lvl};
    x_ext    = {dec_var[DW-1], dec_var};
    half_lvl = r_ext >>> 1;
    full_lvl = r_ext + half_lvl;
    sym_d    = 2'b00;
    level    = -full_lvl;
    if (x_ext >= r_ext) begin
      sym_d = 2'b11;
      level = full_lvl;
    end else if (!x_ext[DW]) begin
      sym_d = 2'b10;
      level = half_lvl;
    end else if (x_ext >= -r_ext) begin
      sym_d = 2'b01;
      level = -half_lvl;
    end
    err_full = x_ext - level;
  end

  // The square is taken on the registered error. The 0s18 result is the squared 1s17 word shifted right by 17.
  assign err_ext     = {{DW{err_out[DW-1]}}, err_out};
  assign prod        = err_ext * err_ext;
  assign sq          = prod[2*DW-2:DW-1];
  assign acc_sum     = acc + {{LOG2_N{1'b0}}, sq};
  assign unused_bits = ^{prod[2*DW-1], prod[DW-2:0], err_full[DW]};

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_out   <= '0;
      err_out   <= '0;
      sym_valid <= 1'b0;
      err_pwr   <= '0;
      sig_pwr   <= '0;
      pwr_valid <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      sym_valid <= sym_clk_en;
      pwr_valid <= 1'b0;
      if (sym_clk_en) begin
        sym_out <= sym_d;
        err_out <= err_full[DW-1:0];
      end
      // A window restart drops any sample that arrives in the same cycle.
      if (clr_win) begin
        acc <= '0;
        cnt <= '0;
      end else if (sym_valid) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          err_pwr   <= acc_sum[AW-1:LOG2_N];
          sig_pwr   <= map_out_pwr;
          pwr_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_slicer_mer.sv
// Directed bench for slicer_mer with 4-symbol windows.
// Each scenario task drives its own vectors and checks against hand-computed values.
module tb_slicer_mer;

  localparam int DW = 18;

  logic                 clk = 1'b0;
  logic                 reset, sym_clk_en, clr_win;
  logic signed [DW-1:0] dec_var, ref_lvl, map_out_pwr;
  logic [1:0]           sym_out;
  logic signed [DW-1:0] err_out;
  logic                 sym_valid;
  logic [DW-1:0]        err_pwr;
  logic signed [DW-1:0] sig_pwr;
  logic                 pwr_valid;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]           got_sym;
  logic signed [DW-1:0] got_err;
  logic                 got_sv, got_pv;

  slicer_mer #(.LOG2_N(2), .DW(DW)) dut (
    .clk(clk), .reset(reset), .sym_clk_en(sym_clk_en), .clr_win(clr_win),
    .dec_var(dec_var), .ref_lvl(ref_lvl), .map_out_pwr(map_out_pwr),
    .sym_out(sym_out), .err_out(err_out), .sym_valid(sym_valid),
    .err_pwr(err_pwr), .sig_pwr(sig_pwr), .pwr_valid(pwr_valid)
  );

  always #5 clk = ~clk;

  // Strobe one symbol, capture the stage-1 outputs, then capture pwr_valid after the stage-2 edge.
  task automatic send(input logic signed [DW-1:0] x);
    dec_var    = x;
    sym_clk_en = 1'b1;
    @(posedge clk); #1;
    sym_clk_en = 1'b0;
    got_sym = sym_out;
    got_err = err_out;
    got_sv  = sym_valid;
    @(posedge clk); #1;
    got_pv = pwr_valid;
  endtask

  task automatic clear_window();
    clr_win = 1'b1;
    @(posedge clk); #1;
    clr_win = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; sym_clk_en = 1'b0; clr_win = 1'b0;
    dec_var = '0; ref_lvl = '0; map_out_pwr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if ({sym_out, err_out, sym_valid} !== '0) begin n_err++; $display("FAIL reset_sym: got sym %0d err %0d v %0b, expected all 0", sym_out, err_out, sym_valid); end
    n_vec++; if ({err_pwr, sig_pwr, pwr_valid} !== '0) begin n_err++; $display("FAIL reset_pwr: got err_pwr %0d sig_pwr %0d pv %0b, expected all 0", err_pwr, sig_pwr, pwr_valid); end
    reset = 1'b0;
  endtask

  task automatic test_slicer();
    logic signed [DW-1:0] xs [6] = '{32768, 32767, 0, -1, -32768, -32769};
    logic [1:0]           es [6] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    logic signed [DW-1:0] ee [6] = '{-16384, 16383, -16384, 16383, -16384, 16383};
    ref_lvl = 32768;
    for (int i = 0; i < 6; i++) begin
      send(xs[i]);
      n_vec++; if (got_sym !== es[i] || got_err !== ee[i] || got_sv !== 1'b1)
        begin n_err++; $display("FAIL slicer[%0d]: got sym %b err %0d v %b, expected sym %b err %0d v 1", i, got_sym, got_err, got_sv, es[i], ee[i]); end
    end
    n_vec++; if (sym_valid !== 1'b0) begin n_err++; $display("FAIL sym_valid_pulse: got %b, expected 0", sym_valid); end
  endtask

  task automatic test_window();
    clear_window();
    ref_lvl = 32768; map_out_pwr = 12345;
    for (int i = 0; i < 4; i++) begin
      send(-32768);
      n_vec++; if (got_pv !== (i == 3)) begin n_err++; $display("FAIL window_pv[%0d]: got %b, expected %b", i, got_pv, (i == 3)); end
    end
    n_vec++; if (err_pwr !== 18'd2048 || sig_pwr !== 12345) begin n_err++; $display("FAIL window_pwr: got err_pwr %0d sig_pwr %0d, expected 2048 12345", err_pwr, sig_pwr); end
    @(posedge clk); #1;
    n_vec++; if (pwr_valid !== 1'b0 || err_pwr !== 18'd2048) begin n_err++; $display("FAIL window_hold: got pv %b err_pwr %0d, expected 0 2048", pwr_valid, err_pwr); end
  endtask

  task automatic test_extremes();
    clear_window();
    ref_lvl = 0; map_out_pwr = -5000;
    for (int i = 0; i < 4; i++) send(-131072);
    n_vec++; if (got_sym !== 2'b00 || got_err !== -131072) begin n_err++; $display("FAIL extreme_slice: got sym %b err %0d, expected 00 -131072", got_sym, got_err); end
    n_vec++; if (got_pv !== 1'b1 || err_pwr !== 18'd131072 || sig_pwr !== -5000)
      begin n_err++; $display("FAIL extreme_pwr: got pv %b err_pwr %0d sig_pwr %0d, expected 1 131072 -5000", got_pv, err_pwr, sig_pwr); end
  endtask

  task automatic test_clear_collision();
    clear_window();
    ref_lvl = 32768; map_out_pwr = 777;
    send(-32768);
    send(-32768);
    // Third symbol: clr_win lands on its stage-2 cycle.
    dec_var = -32768; sym_clk_en = 1'b1;
    @(posedge clk); #1;
    sym_clk_en = 1'b0; clr_win = 1'b1;
    @(posedge clk); #1;
    clr_win = 1'b0;
    n_vec++; if (pwr_valid !== 1'b0) begin n_err++; $display("FAIL collide_pv3: got %b, expected 0", pwr_valid); end
    send(-32768);
    n_vec++; if (got_pv !== 1'b0 || err_pwr !== 18'd131072) begin n_err++; $display("FAIL collide_pv4: got pv %b err_pwr %0d, expected 0 131072", got_pv, err_pwr); end
    for (int i = 0; i < 3; i++) begin
      send(-32768);
      n_vec++; if (got_pv !== (i == 2)) begin n_err++; $display("FAIL collide_after[%0d]: got %b, expected %b", i, got_pv, (i == 2)); end
    end
    n_vec++; if (err_pwr !== 18'd2048 || sig_pwr !== 777) begin n_err++; $display("FAIL collide_pwr: got err_pwr %0d sig_pwr %0d, expected 2048 777", err_pwr, sig_pwr); end
  endtask

  task automatic test_neg_ref();
    ref_lvl = -1000;
    send(500);
    n_vec++; if (got_sym !== 2'b11 || got_err !== 500) begin n_err++; $display("FAIL neg_ref: got sym %b err %0d, expected 11 500", got_sym, got_err); end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] xs [4] = '{32768, 0, -1, -32769};
    logic [1:0]           es [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    logic signed [DW-1:0] ee [4] = '{-16384, -16384, 16383, 16383};
    clear_window();
    ref_lvl = 32768; map_out_pwr = 99;
    sym_clk_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dec_var = xs[i];
      @(posedge clk); #1;
      n_vec++; if (sym_out !== es[i] || err_out !== ee[i] || sym_valid !== 1'b1)
        begin n_err++; $display("FAIL b2b[%0d]: got sym %b err %0d v %b, expected sym %b err %0d v 1", i, sym_out, err_out, sym_valid, es[i], ee[i]); end
    end
    sym_clk_en = 1'b0;
    @(posedge clk); #1;
    // (2048 + 2047 + 2047 + 2048) / 4 = 2047
    n_vec++; if (pwr_valid !== 1'b1 || err_pwr !== 18'd2047 || sig_pwr !== 99)
      begin n_err++; $display("FAIL b2b_pwr: got pv %b err_pwr %0d sig_pwr %0d, expected 1 2047 99", pwr_valid, err_pwr, sig_pwr); end
  endtask

  task automatic test_reset_midwindow();
    ref_lvl = 32768; map_out_pwr = 4321;
    send(0);
    send(0);
    reset = 1'b1; sym_clk_en = 1'b1; dec_var = 32768;
    @(posedge clk); #1;
    reset = 1'b0; sym_clk_en = 1'b0;
    n_vec++; if ({sym_out, err_out, sym_valid, err_pwr, sig_pwr, pwr_valid} !== '0)
      begin n_err++; $display("FAIL midreset: got sym %0d err %0d sv %b err_pwr %0d sig_pwr %0d pv %b, expected all 0", sym_out, err_out, sym_valid, err_pwr, sig_pwr, pwr_valid); end
    for (int i = 0; i < 4; i++) begin
      send(0);
      n_vec++; if (got_pv !== (i == 3)) begin n_err++; $display("FAIL midreset_win[%0d]: got %b, expected %b", i, got_pv, (i == 3)); end
    end
    n_vec++; if (err_pwr !== 18'd2048 || sig_pwr !== 4321) begin n_err++; $display("FAIL midreset_pwr: got err_pwr %0d sig_pwr %0d, expected 2048 4321", err_pwr, sig_pwr); end
  endtask

  initial begin
    test_reset();
    test_slicer();
    test_window();
    test_extremes();
    test_clear_collision();
    test_neg_ref();
    test_back_to_back();
    test_reset_midwindow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/slicer_mer.md
Name: slicer_mer

Overview:
- Downstream consumer of the average-magnitude stage. Receives the 4-ASK decision variable plus the reference level and mapper-output power that stage produces.
- On each symbol enable it:
  - slices the decision variable into a 2-bit symbol decision;
  - forms the slicer error against the ideal constellation point;
  - accumulates squared error over a window of 2^LOG2_N symbols.
- Emits the mean error power once per window, paired with map_out_pwr for MER measurement in the receiver chain.

Parameters:
- LOG2_N, 4, log2 of the number of symbols per error-power window; valid range 1..20.
- DW, 18, width of the decision variable, reference level and power words (1s17 format).

Ports:
- clk  input  1  system clock (sys_clk).
- reset  input  1  synchronous, active-high reset.
- sym_clk_en  input  1  one-cycle symbol strobe; all sampling is qualified by it.
- clr_win  input  1  synchronous window restart; aligns the window with the average-magnitude stage's clear.
- dec_var  input  DW signed  decision variable, 1s17.
- ref_lvl  input  DW signed  reference level (mean |x| = 2a), 1s17; negative values are treated as 0.
- map_out_pwr  input  DW signed  mapper output power, latched alongside each err_pwr result.
- sym_out  output  2  sliced symbol: 00 = -3a, 01 = -a, 10 = +a, 11 = +3a.
- err_out  output  DW signed  slicer error, 1s17.
- sym_valid  output  1  one-cycle pulse when sym_out/err_out update.
- err_pwr  output  DW unsigned  mean squared error of the last window, 0s18 scaling of the squared 1s17 word.
- sig_pwr  output  DW signed  map_out_pwr captured on the same cycle err_pwr updates.
- pwr_valid  output  1  one-cycle pulse when err_pwr/sig_pwr update.

Behaviour:
- Reset: all outputs, pipeline registers, accumulator and symbol counter are 0. Reset overrides every other input.
- Stage 1, on the cycle sym_clk_en = 1:
  - Clamp: r = max(ref_lvl, 0).
  - Decision thresholds:
    - x >= r gives 11, ideal level +1.5r;
    - 0 <= x < r gives 10, ideal level +0.5r;
    - -r <= x < 0 gives 01, ideal level -0.5r;
    - x < -r gives 00, ideal level -1.5r.
  - Ideal levels: compute in 19 bits as r + (r >>> 1) or r >>> 1 (arithmetic shift, truncating); negate for the lower symbols.
  - err = x - level, computed in 19 bits. Its magnitude provably fits in DW, so store the low DW bits.
  - sym_out and err_out are registered on the next edge; sym_valid pulses for exactly that one cycle. Latency is 1 clk.
- Stage 2, on the cycle sym_valid = 1:
  - prod = err_out * err_out (2*DW signed).
  - sq = prod[2*DW-2 : DW-1] as unsigned DW bits; range 0..131072.
  - acc (DW+LOG2_N bits, unsigned) adds sq; cnt (LOG2_N bits) increments.
- Window end, when cnt = 2^LOG2_N - 1 on a stage-2 cycle:
  - err_pwr <= (acc + sq) >> LOG2_N, taking bits [DW+LOG2_N-1 : LOG2_N].
  - sig_pwr <= map_out_pwr.
  - pwr_valid pulses for 1 clk.
  - acc <= 0 and cnt wraps to 0.
  - Latency from the sym_clk_en of the last symbol to pwr_valid is 2 clk.
- Outputs between events: err_pwr and sig_pwr hold their value until the next window end.
- clr_win = 1:
  - acc and cnt are cleared next edge; err_pwr and sig_pwr are held.
  - If clr_win coincides with a stage-2 cycle, clear wins: the sample is discarded and no pwr_valid is generated.
  - Stage-1 registers are unaffected.
- sym_clk_en is never asserted on consecutive cycles in the system. The block must still be correct if it is, because the pipeline is fully registered.
- No overflow: acc max = 2^LOG2_N * 131072, which fits in DW+LOG2_N bits.

Test Plan:
- Reset mid-window → all outputs 0 next clk. After release, the first window needs a full 2^LOG2_N symbols before pwr_valid.
- Slicer boundaries with ref_lvl = 32768 → required responses:
  - dec_var 32768 → sym 11, err -16384;
  - dec_var 32767 → sym 10, err 16383;
  - dec_var 0 → sym 10, err -16384;
  - dec_var -1 → sym 01, err 16383;
  - dec_var -32768 → sym 01, err -16384;
  - dec_var -32769 → sym 00, err 16383.
- Window average with LOG2_N = 2, ref_lvl = 32768, four symbols of dec_var = -32768 → each sq = 2048. pwr_valid fires 2 clk after the 4th sym_clk_en with err_pwr = 2048, and sig_pwr equals the map_out_pwr present that cycle.
- Extremes with ref_lvl = 0 and dec_var = -131072 → sym 00, err -131072, sq 131072. With LOG2_N = 2 this gives err_pwr = 131072 (unsigned, no wrap).
- Clear collision: assert clr_win on the 3rd stage-2 cycle of a LOG2_N = 2 window → no pwr_valid at the expected point, err_pwr holds its old value, and the next pwr_valid arrives 4 symbols after the clear.
- Negative ref_lvl = -1000 with dec_var = 500 → treated as r = 0: sym 11, err 500.
